// File: rtl/or16_bist.sv
// or16_bist: self-test sequencer for a WIDTH-bit bitwise OR unit.
// It sweeps operand A (outer) and B (inner) exhaustively, holds each vector
// for SETTLE_CYC+1 cycles, then checks the unit's result against A|B.
// Mismatches are counted (saturating), and the first failing vector is captured.
module or16_bist #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] A_LAST     = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] B_LAST     = {WIDTH{1'b1}},
  parameter int               SETTLE_CYC = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             ABORT,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] OUT_DUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [15:0]      ERR_COUNT,
  output logic [WIDTH-1:0] FAIL_A,
  output logic [WIDTH-1:0] FAIL_B,
  output logic [WIDTH-1:0] FAIL_OUT
);

  // Settle counter is sized to hold SETTLE_CYC; at least one bit wide.
  localparam int CW = (SETTLE_CYC > 0) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [15:0]      r_err;
  logic [WIDTH-1:0] r_fail_a;
  logic [WIDTH-1:0] r_fail_b;
  logic [WIDTH-1:0] r_fail_out;

  logic [WIDTH-1:0] w_expect;
  logic             w_check;
  logic             w_mismatch;
  logic             w_first;
  logic [15:0]      w_err_inc;
  logic             w_last_a;
  logic             w_last_b;
  logic             w_clean_end;

  // Compare the unit's result against the golden OR and prepare the error update.
  always_comb begin
    w_expect    = r_a | r_b;
    w_check     = (r_cnt == {CW{1'b0}});
    w_mismatch  = (OUT_DUT != w_expect);
    w_first     = w_mismatch && (r_err == 16'd0);
    if (r_err == 16'hFFFF) begin
      w_err_inc = r_err;
    end else begin
      w_err_inc = r_err + 16'd1;
    end
    w_last_a    = (r_a == A_LAST);
    w_last_b    = (r_b == B_LAST);
    // Error count after this check cycle is still zero.
    w_clean_end = (r_err == 16'd0) && !w_mismatch;
  end

  // Sequencer: start/abort handling, vector hold, compare and sweep advance.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_cnt      <= {CW{1'b0}};
      r_a        <= {WIDTH{1'b0}};
      r_b        <= {WIDTH{1'b0}};
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_err      <= 16'd0;
      r_fail_a   <= {WIDTH{1'b0}};
      r_fail_b   <= {WIDTH{1'b0}};
      r_fail_out <= {WIDTH{1'b0}};
    end else if (ABORT) begin
      // Operands, count and first-fail capture are kept for debug.
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            r_state    <= ST_RUN;
            r_cnt      <= SETTLE_LD;
            r_a        <= {WIDTH{1'b0}};
            r_b        <= {WIDTH{1'b0}};
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= 16'd0;
            r_fail_a   <= {WIDTH{1'b0}};
            r_fail_b   <= {WIDTH{1'b0}};
            r_fail_out <= {WIDTH{1'b0}};
          end else begin
            r_state <= r_state;
          end
        end
        ST_RUN: begin
          if (!w_check) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            if (w_mismatch) begin
              r_err <= w_err_inc;
              if (w_first) begin
                r_fail_a   <= r_a;
                r_fail_b   <= r_b;
                r_fail_out <= OUT_DUT;
              end else begin
                r_fail_a <= r_fail_a;
              end
            end else begin
              r_err <= r_err;
            end
            r_cnt <= SETTLE_LD;
            if (!w_last_b) begin
              r_b <= r_b + WIDTH'(1);
            end else if (!w_last_a) begin
              r_b <= {WIDTH{1'b0}};
              r_a <= r_a + WIDTH'(1);
            end else begin
              // Terminal vector checked: operands stay on it.
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= w_clean_end;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_pass  <= 1'b0;
        end
      endcase
    end
  end

  assign A         = r_a;
  assign B         = r_b;
  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign PASS      = r_pass;
  assign ERR_COUNT = r_err;
  assign FAIL_A    = r_fail_a;
  assign FAIL_B    = r_fail_b;
  assign FAIL_OUT  = r_fail_out;

endmodule

// File: tb/tb_or16_bist.sv
// Bench for or16_bist: four instances with different sweep sizes and OR-unit
// models. Stimulus pushes expected vectors/results into queues; negedge
// monitors pop and compare whenever an instance is busy or raises DONE.
module tb_or16_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst_z;
  logic st_g, st_f, st_s, st_z, ab_g, ab_f, ab_s, ab_z;

  logic [15:0] a_g, b_g, o_g, err_g, fa_g, fb_g, fo_g;
  logic [15:0] a_f, b_f, o_f, err_f, fa_f, fb_f, fo_f;
  logic [15:0] a_s, b_s, o_s, err_s, fa_s, fb_s, fo_s;
  logic [15:0] a_z, b_z, o_z, err_z, fa_z, fb_z, fo_z;
  logic busy_g, done_g, pass_g, busy_f, done_f, pass_f;
  logic busy_s, done_s, pass_s, busy_z, done_z, pass_z;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  int s_cyc = 0;
  int acc_g, acc_f, acc_s, acc_z;

  typedef struct {
    logic [15:0] err;
    logic [15:0] fa;
    logic [15:0] fb;
    logic [15:0] fo;
    logic        pass;
    int          lat;
  } res_t;

  res_t        q_res_g[$];
  res_t        q_res_f[$];
  res_t        q_res_s[$];
  logic [31:0] q_vec_g[$];
  logic [31:0] q_vec_s[$];

  // OR-unit models: golden, bit0 stuck-at-0, golden only on check cycles, all-zero.
  assign o_g = a_g | b_g;
  assign o_f = (a_f | b_f) & 16'hFFFE;
  assign o_s = (s_cyc % 3 == 2) ? (a_s | b_s) : ~(a_s | b_s);
  assign o_z = 16'h0000;

  or16_bist #(.WIDTH(16), .A_LAST(16'd3), .B_LAST(16'd3), .SETTLE_CYC(0)) u_g (
    .CLK(clk), .RST(rst), .START(st_g), .ABORT(ab_g), .A(a_g), .B(b_g), .OUT_DUT(o_g),
    .BUSY(busy_g), .DONE(done_g), .PASS(pass_g), .ERR_COUNT(err_g),
    .FAIL_A(fa_g), .FAIL_B(fb_g), .FAIL_OUT(fo_g));

  or16_bist #(.WIDTH(16), .A_LAST(16'd3), .B_LAST(16'd3), .SETTLE_CYC(0)) u_f (
    .CLK(clk), .RST(rst), .START(st_f), .ABORT(ab_f), .A(a_f), .B(b_f), .OUT_DUT(o_f),
    .BUSY(busy_f), .DONE(done_f), .PASS(pass_f), .ERR_COUNT(err_f),
    .FAIL_A(fa_f), .FAIL_B(fb_f), .FAIL_OUT(fo_f));

  or16_bist #(.WIDTH(16), .A_LAST(16'd1), .B_LAST(16'd1), .SETTLE_CYC(2)) u_s (
    .CLK(clk), .RST(rst), .START(st_s), .ABORT(ab_s), .A(a_s), .B(b_s), .OUT_DUT(o_s),
    .BUSY(busy_s), .DONE(done_s), .PASS(pass_s), .ERR_COUNT(err_s),
    .FAIL_A(fa_s), .FAIL_B(fb_s), .FAIL_OUT(fo_s));

  or16_bist #(.WIDTH(16), .A_LAST(16'hFFFF), .B_LAST(16'hFFFF), .SETTLE_CYC(0)) u_z (
    .CLK(clk), .RST(rst_z), .START(st_z), .ABORT(ab_z), .A(a_z), .B(b_z), .OUT_DUT(o_z),
    .BUSY(busy_z), .DONE(done_z), .PASS(pass_z), .ERR_COUNT(err_z),
    .FAIL_A(fa_z), .FAIL_B(fb_z), .FAIL_OUT(fo_z));

  // Free-running edge counter and the settle-phase counter for u_s.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    s_cyc <= busy_s ? s_cyc + 1 : 0;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input res_t e, input logic [15:0] err,
                         input logic [15:0] fa, input logic [15:0] fb,
                         input logic [15:0] fo, input logic pass, input int lat);
    chk({nm, "_err"}, err, e.err);
    chk({nm, "_fail"}, {fa, fb, fo}, {e.fa, e.fb, e.fo});
    chk({nm, "_pass"}, pass, e.pass);
    chk({nm, "_latency"}, lat, e.lat);
  endtask

  task automatic unexpected(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: output presented, none expected", nm);
  endtask

  logic pd_g = 1'b0, pd_f = 1'b0, pd_s = 1'b0;

  // Monitor: per-cycle vectors while busy, final result on DONE rising.
  always @(negedge clk) begin
    if (busy_g) begin
      if (q_vec_g.size() == 0) unexpected("g_vec");
      else chk("g_vec", {a_g, b_g}, q_vec_g.pop_front());
    end
    if (busy_s) begin
      if (q_vec_s.size() == 0) unexpected("s_vec");
      else chk("s_vec", {a_s, b_s}, q_vec_s.pop_front());
    end
    if (done_g && !pd_g) begin
      if (q_res_g.size() == 0) unexpected("g_done");
      else chk_res("g", q_res_g.pop_front(), err_g, fa_g, fb_g, fo_g, pass_g, cyc - acc_g);
    end
    if (done_f && !pd_f) begin
      if (q_res_f.size() == 0) unexpected("f_done");
      else chk_res("f", q_res_f.pop_front(), err_f, fa_f, fb_f, fo_f, pass_f, cyc - acc_f);
    end
    if (done_s && !pd_s) begin
      if (q_res_s.size() == 0) unexpected("s_done");
      else chk_res("s", q_res_s.pop_front(), err_s, fa_s, fb_s, fo_s, pass_s, cyc - acc_s);
    end
    pd_g <= done_g;
    pd_f <= done_f;
    pd_s <= done_s;
  end

  task automatic pulse(input logic g, input logic f, input logic s, input logic z);
    @(negedge clk);
    st_g = g; st_f = f; st_s = s; st_z = z;
    @(posedge clk);
    #1;
    if (g) acc_g = cyc;
    if (f) acc_f = cyc;
    if (s) acc_s = cyc;
    if (z) acc_z = cyc;
    st_g = 1'b0; st_f = 1'b0; st_s = 1'b0; st_z = 1'b0;
  endtask

  task automatic push_g_vecs(input int n);
    for (int i = 0; i < n; i++) q_vec_g.push_back({16'(i / 4), 16'(i % 4)});
  endtask

  function automatic int pending();
    return q_vec_g.size() + q_vec_s.size() + q_res_g.size() + q_res_f.size() + q_res_s.size();
  endfunction

  task automatic drain(input string nm, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (pending() == 0) break;
      @(negedge clk);
    end
    chk(nm, pending(), 0);
  endtask

  initial begin
    res_t r_gold, r_stuck, r_slow;
    r_gold  = '{err: 16'd0,  fa: 16'd0, fb: 16'd0, fo: 16'd0, pass: 1'b1, lat: 16};
    r_stuck = '{err: 16'd12, fa: 16'd0, fb: 16'd1, fo: 16'd0, pass: 1'b0, lat: 16};
    r_slow  = '{err: 16'd0,  fa: 16'd0, fb: 16'd0, fo: 16'd0, pass: 1'b1, lat: 12};

    rst = 1'b1; rst_z = 1'b1;
    st_g = 1'b0; st_f = 1'b0; st_s = 1'b0; st_z = 1'b0;
    ab_g = 1'b0; ab_f = 1'b0; ab_s = 1'b0; ab_z = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ab", {a_g, b_g}, 32'd0);
    chk("reset_flags", {busy_g, done_g, pass_g}, 3'b000);
    chk("reset_err", err_g, 16'd0);
    chk("reset_fail", {fa_g, fb_g, fo_g}, 48'd0);
    rst = 1'b0; rst_z = 1'b0;

    // Long all-zero-output sweep runs in the background for saturation.
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("z_err_count_100", err_z, 16'd99);

    // Golden, stuck-bit and settle-2 sweeps together.
    push_g_vecs(16);
    q_res_g.push_back(r_gold);
    q_res_f.push_back(r_stuck);
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        repeat (3) q_vec_s.push_back({16'(a), 16'(b)});
    q_res_s.push_back(r_slow);
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    drain("drain_first_sweeps", 60);
    chk("g_done_hold", {busy_g, done_g, pass_g, a_g, b_g}, {3'b011, 16'd3, 16'd3});
    chk("f_done_hold", {done_f, pass_f}, 2'b10);

    // Restart from DONE; a START during RUN is ignored.
    push_g_vecs(16);
    q_res_g.push_back(r_gold);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    chk("g_restart_flags", {busy_g, done_g, pass_g, a_g, b_g}, {3'b100, 32'd0});
    repeat (3) @(posedge clk);
    #1 st_g = 1'b1;
    @(posedge clk);
    #1 st_g = 1'b0;
    drain("drain_restart", 60);

    // ABORT while (1,2) is presented.
    push_g_vecs(7);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 ab_g = 1'b1; ab_f = 1'b1;
    @(posedge clk);
    #1 ab_g = 1'b0; ab_f = 1'b0;
    chk("abort_flags", {busy_g, done_g, pass_g}, 3'b000);
    chk("abort_ab_hold", {a_g, b_g}, {16'd1, 16'd2});
    chk("abort_f_err_hold", err_f, 16'd4);
    chk("abort_f_fail_hold", {fa_f, fb_f, fo_f}, {16'd0, 16'd1, 16'd0});
    chk("abort_vec_left", q_vec_g.size(), 0);
    @(negedge clk);
    chk("abort_no_done", {done_g, done_f}, 2'b00);

    // ABORT beats START in the same cycle.
    st_g = 1'b1; ab_g = 1'b1;
    @(posedge clk);
    #1 st_g = 1'b0; ab_g = 1'b0;
    chk("abort_wins", {busy_g, done_g, a_g, b_g}, {2'b00, 16'd1, 16'd2});

    // Restart after abort clears count and capture.
    push_g_vecs(16);
    q_res_g.push_back(r_gold);
    q_res_f.push_back(r_stuck);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    chk("f_restart_clear", {err_f, fa_f, fb_f, fo_f, a_f, b_f}, 96'd0);
    drain("drain_after_abort", 60);

    // Asynchronous reset between edges mid-run.
    push_g_vecs(3);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_g", {busy_g, done_g, pass_g, a_g, b_g}, 35'd0);
    chk("async_rst_f", {done_f, err_f, fa_f, fb_f, fo_f}, 65'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("async_rst_no_done", {busy_g, done_g}, 2'b00);
    drain("drain_after_rst", 4);

    // Saturation of the all-zero sweep.
    while (cyc < acc_z + 65540) @(posedge clk);
    @(negedge clk);
    chk("z_err_saturated", err_z, 16'hFFFF);
    chk("z_first_fail", {fa_z, fb_z, fo_z}, {16'd0, 16'd1, 16'd0});
    chk("z_flags", {busy_z, done_z, pass_z}, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/or16_bist.md
Name: or16_bist

Overview:
- Built-in self-test sequencer that sits on both sides of the 16-bit bitwise OR unit.
- Upstream, it drives operands A and B through an exhaustive nested sweep: A outer, B inner.
- Downstream, it samples the unit's OUT, compares it to A|B and counts mismatches.
- It moves exhaustive OR checking from simulation-only stimulus into synthesizable hardware usable on FPGA.

Parameters:
WIDTH, 16, operand/result width in bits
A_LAST, 16'hFFFF, final value of A in the sweep (A runs 0..A_LAST)
B_LAST, 16'hFFFF, final value of B in the sweep (B runs 0..B_LAST)
SETTLE_CYC, 1, extra cycles each vector is held before OUT is sampled (0 allowed)

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  asynchronous active-high reset
START  in  1  one-cycle start pulse; honoured only in IDLE or DONE
ABORT  in  1  stop the sweep and return to IDLE; DONE is not raised
A  out  WIDTH  operand A to the OR unit (registered)
B  out  WIDTH  operand B to the OR unit (registered)
OUT_DUT  in  WIDTH  result from the OR unit (combinational from A/B)
BUSY  out  1  high while the sweep is running
DONE  out  1  high from sweep completion until the next START, ABORT or RST
PASS  out  1  DONE && ERR_COUNT==0
ERR_COUNT  out  16  mismatch count, saturates at 16'hFFFF
FAIL_A  out  WIDTH  A of the first mismatch; 0 if none
FAIL_B  out  WIDTH  B of the first mismatch; 0 if none
FAIL_OUT  out  WIDTH  OUT_DUT of the first mismatch; 0 if none

Behaviour:
- Clocking and reset: single clock CLK; RST is asynchronous and active-high.
- Reset values: state=IDLE; all outputs 0 (A, B, BUSY, DONE, PASS, ERR_COUNT, FAIL_*); settle counter 0.
- States: IDLE, RUN, DONE.
- IDLE: outputs hold. On START:
  - A<=0, B<=0, ERR_COUNT<=0, FAIL_*<=0, settle counter<=SETTLE_CYC.
  - BUSY<=1, state->RUN.
- RUN: each (A,B) vector is held for exactly SETTLE_CYC+1 cycles.
  - While the counter is nonzero, decrement it.
  - Check cycle (counter==0): compare OUT_DUT with A|B.
  - On mismatch: ERR_COUNT increments, saturating at FFFF. FAIL_A/B/OUT load only if ERR_COUNT was 0 before the increment.
  - Advance, in the same check cycle:
    - if B!=B_LAST: B<=B+1
    - else if A!=A_LAST: B<=0, A<=A+1
    - else: state->DONE, BUSY<=0, DONE<=1
  - The counter reloads to SETTLE_CYC on every advance.
- DONE:
  - A/B hold their last values.
  - ERR_COUNT and FAIL_* hold.
  - PASS = (ERR_COUNT==0).
  - START restarts exactly as from IDLE, with DONE and PASS dropping the same cycle BUSY rises.
- Latency: the first compare occurs SETTLE_CYC+1 cycles after the START-accept edge. Total run = (A_LAST+1)*(B_LAST+1)*(SETTLE_CYC+1) cycles.
- Wrap-around: no counter wraps. With defaults, A=FFFF and B=FFFF are the terminal vector and are checked; the next vector is never 0/0.
- START while in RUN: ignored.
- ABORT from any state: state->IDLE, BUSY=0, DONE=0, PASS=0. A, B, ERR_COUNT and FAIL_* hold for debug.
- ABORT and START in the same cycle: ABORT wins.
- RST mid-run: immediate return to reset values; no partial DONE.
- PASS is never 1 outside DONE.
- Comparison is full-width, bitwise, exact; no X-tolerance.

Test Plan:
- Golden DUT, A_LAST=3, B_LAST=3, SETTLE_CYC=0, START pulse -> 16 vectors (0,0),(0,1)..(3,3) in order. DONE rises 16 cycles after accept; PASS=1, ERR_COUNT=0, FAIL_*=0.
- DUT with bit0 of OUT stuck-at-0, same params -> ERR_COUNT=12 (vectors with A|B odd). FAIL_A=0, FAIL_B=1, FAIL_OUT=0; PASS=0.
- SETTLE_CYC=2, A_LAST=1, B_LAST=1, golden -> each vector held 3 cycles. DONE at cycle 12 after accept; OUT sampled only on the third cycle of each vector.
- ABORT asserted at vector (1,2) with A_LAST=B_LAST=3 -> IDLE next cycle, BUSY=0, DONE=0, A=1, B=2 held. A following START restarts at (0,0) with ERR_COUNT cleared.
- RST pulsed asynchronously mid-run (between clock edges) -> all outputs 0 immediately. START ignored during RUN; START in DONE restarts cleanly.
- DUT forced to output 0, A_LAST=B_LAST=FFFF, run long -> ERR_COUNT saturates at FFFF, never wraps. FAIL_A=0, FAIL_B=1.
